// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request, one-entry output buffer; redirect squashes stale responses.
// Latency: response lands in the buffer the cycle after imem_rsp_valid. Backpressure: a full, unconsumed buffer holds off the next request.
module ifetch_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_pc,
  output logic [DATA_WIDTH-1:0] inst
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] pc, pc_nxt;
  logic                  inst_valid_nxt;
  logic                  load;
  logic                  req_hs;

  assign imem_addr      = pc;
  assign imem_req_valid = (state == REQ) && (!inst_valid || inst_ready);
  assign req_hs         = imem_req_valid && imem_req_ready;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    load           = 1'b0;
    inst_valid_nxt = inst_valid && !inst_ready;

    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (req_hs) state_nxt = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt = REQ;
          if (!redirect_valid) begin
            load           = 1'b1;
            pc_nxt         = pc + DATA_WIDTH'(4);
            inst_valid_nxt = 1'b1;
          end
        end else if (redirect_valid) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        // The stale response retires the in-flight request; the current pc is fetched next.
        if (imem_rsp_valid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase

    if (redirect_valid) begin
      pc_nxt         = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
      inst_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst_valid <= inst_valid_nxt;
      if (load) begin
        inst    <= imem_rsp_data;
        inst_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: inputs change at negedge, outputs checked 1ns later.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst;

  int n_checks = 0;
  int n_fails  = 0;

  ifetch_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst           (inst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next negedge, drive inputs, then let combinational outputs settle.
  task automatic cyc(input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic ir, input logic redir, input logic [31:0] rpc);
    @(negedge clk);
    imem_req_ready = rdy;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    inst_ready     = ir;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic chk_buf(input string tag, input logic v, input logic [31:0] pcx, input logic [31:0] d);
    chk({tag, "_inst_valid"}, {31'b0, inst_valid}, {31'b0, v});
    chk({tag, "_inst_pc"}, inst_pc, pcx);
    chk({tag, "_inst"}, inst, d);
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
    chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, {31'b0, v});
    chk({tag, "_addr"}, imem_addr, a);
  endtask

  initial begin
    rst = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0;

    // Reset state
    #6;
    chk_req("rst", 1'b0, 32'h8000_0000);
    chk_buf("rst", 1'b0, 32'h0, 32'h0);

    // Release reset; IDLE for one cycle, request visible for the second posedge
    @(negedge clk); rst = 1'b1; #1;
    chk_req("idle", 1'b0, 32'h8000_0000);
    cyc(1, 0, 0, 0, 0, 0);
    chk_req("first_req", 1'b1, 32'h8000_0000);
    cyc(1, 1, 32'h0000_0013, 0, 0, 0);
    chk("wait_no_req", {31'b0, imem_req_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_buf("fetch0", 1'b1, 32'h8000_0000, 32'h0000_0013);
    chk_req("fetch0_next", 1'b0, 32'h8000_0004);

    // Stall: buffer held, no request
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      chk_buf("stall", 1'b1, 32'h8000_0000, 32'h0000_0013);
      chk("stall_req", {31'b0, imem_req_valid}, 32'h0);
    end
    cyc(1, 0, 0, 1, 0, 0);
    chk_req("consume_req", 1'b1, 32'h8000_0004);

    // Redirect in WAIT, stale response two cycles later
    cyc(0, 0, 0, 0, 1, 32'h8000_0102);
    chk("consumed", {31'b0, inst_valid}, 32'h0);
    chk("wait_req", {31'b0, imem_req_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_req("drop", 1'b0, 32'h8000_0100);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("drop_rsp_iv", {31'b0, inst_valid}, 32'h0);
    chk("drop_rsp_req", {31'b0, imem_req_valid}, 32'h0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("after_drop_iv", {31'b0, inst_valid}, 32'h0);
    chk_req("after_drop", 1'b1, 32'h8000_0100);

    // Redirect coincident with response in WAIT
    cyc(0, 1, 32'h1111_1111, 0, 1, 32'h8000_0200);
    cyc(1, 0, 0, 0, 0, 0);
    chk("coinc_iv", {31'b0, inst_valid}, 32'h0);
    chk_req("coinc", 1'b1, 32'h8000_0200);
    cyc(0, 1, 32'h2222_2222, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_buf("fetch1", 1'b1, 32'h8000_0200, 32'h2222_2222);
    chk_req("fetch1_next", 1'b0, 32'h8000_0204);

    // Redirect with unconsumed buffer, low bits masked; then wrap
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    cyc(1, 0, 0, 0, 0, 0);
    chk("redir_clr_iv", {31'b0, inst_valid}, 32'h0);
    chk_req("wrap_req", 1'b1, 32'hFFFF_FFFC);
    cyc(0, 1, 32'h3333_3333, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_buf("wrap", 1'b1, 32'hFFFF_FFFC, 32'h3333_3333);
    chk_req("wrap_next", 1'b0, 32'h0000_0000);

    // Async reset with a valid buffer
    #2 rst = 1'b0; #1;
    chk_buf("arst1", 1'b0, 32'h0, 32'h0);
    chk_req("arst1", 1'b0, 32'h8000_0000);
    @(negedge clk); rst = 1'b1; #1;
    chk_req("rel1", 1'b0, 32'h8000_0000);
    cyc(1, 0, 0, 0, 0, 0);
    chk_req("restart1", 1'b1, 32'h8000_0000);

    // Async reset in WAIT with a request outstanding
    cyc(0, 0, 0, 0, 0, 0);
    chk("wait2_req", {31'b0, imem_req_valid}, 32'h0);
    #2 rst = 1'b0; #1;
    chk_req("arst2", 1'b0, 32'h8000_0000);
    @(negedge clk); rst = 1'b1; #1;
    cyc(1, 0, 0, 0, 0, 0);
    chk_req("restart2", 1'b1, 32'h8000_0000);
    cyc(0, 1, 32'h0000_0044, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_buf("fetch_after_rst", 1'b1, 32'h8000_0000, 32'h0000_0044);
    chk_req("fetch_after_rst_next", 1'b0, 32'h8000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of PC, address and instruction.
REQ-002 Parameter: RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: redirect_valid  input  1  branch/jump redirect from execute, single-cycle pulse.
REQ-006 Port: redirect_pc  input  DATA_WIDTH  redirect target.
REQ-007 Port: imem_req_valid  output  1  fetch request to instruction memory.
REQ-008 Port: imem_req_ready  input  1  memory accepts the request.
REQ-009 Port: imem_addr  output  DATA_WIDTH  fetch address.
REQ-010 Port: imem_rsp_valid  input  1  response data valid; one response per accepted request, in order.
REQ-011 Port: imem_rsp_data  input  DATA_WIDTH  fetched instruction.
REQ-012 Port: inst_valid  output  1  fetched instruction available to the fetch stage.
REQ-013 Port: inst_ready  input  1  fetch stage consumes the instruction.
REQ-014 Port: inst_pc  output  DATA_WIDTH  PC of the presented instruction.
REQ-015 Port: inst  output  DATA_WIDTH  presented instruction.

Function
REQ-016 Internal PC register pc and FSM with states IDLE, REQ, WAIT, DROP shall exist; at most one memory request outstanding.
REQ-017 IDLE: entered on reset; unconditionally moves to REQ next cycle; imem_req_valid=0.
REQ-018 REQ: imem_req_valid=1 only when output buffer is empty (inst_valid=0) or is consumed this cycle (inst_valid & inst_ready); imem_addr=pc.
REQ-019 REQ: handshake (imem_req_valid & imem_req_ready) without redirect moves to WAIT.
REQ-020 WAIT: imem_rsp_valid without redirect loads inst<=imem_rsp_data, inst_pc<=pc, inst_valid<=1, pc<=pc+4 (modulo 2^DATA_WIDTH, wraps), moves to REQ.
REQ-021 Output buffer shall hold inst/inst_pc stable while inst_valid=1 and inst_ready=0; inst_valid clears the cycle after inst_valid & inst_ready unless reloaded.
REQ-022 Redirect (highest priority, any state): pc<={redirect_pc[DATA_WIDTH-1:2],2'b00}, inst_valid<=0 next cycle.
REQ-023 Redirect in REQ without handshake: stay REQ; new address presented next cycle.
REQ-024 Redirect in REQ coinciding with handshake: move to DROP (stale request in flight).
REQ-025 Redirect in WAIT without imem_rsp_valid: move to DROP.
REQ-026 Redirect in WAIT coinciding with imem_rsp_valid: response discarded, move to REQ.
REQ-027 DROP: imem_req_valid=0; imem_rsp_valid discards the response, moves to REQ; redirect in DROP updates pc, stays DROP.
REQ-028 Redirect in IDLE updates pc; move to REQ as normal.
REQ-029 Discarded responses shall never set inst_valid.
REQ-030 imem_addr shall equal pc in every state; imem_req_valid shall be low outside REQ.

Reset
REQ-031 rst=0 shall asynchronously force: state=IDLE, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, imem_req_valid=0.
REQ-032 Reset asserted mid-transaction shall abandon the outstanding request; after release no response is expected from the abandoned request (memory reset together).
REQ-033 First imem_req_valid shall assert the second posedge after rst deasserts, with imem_addr=RESET_PC.

Verification
REQ-034 Release reset, req_ready=1, rsp 1 cycle later with 32'h0000_0013 -> inst_valid=1, inst_pc=32'h8000_0000, inst=32'h0000_0013; next request addr 32'h8000_0004.
REQ-035 inst_ready=0 for 5 cycles with inst_valid=1 -> inst/inst_pc stable, imem_req_valid=0; inst_ready=1 -> request for next PC same cycle.
REQ-036 Redirect to 32'h8000_0102 while in WAIT, response arrives 2 cycles later -> response dropped, next request addr 32'h8000_0100, no inst_valid from dropped data.
REQ-037 Redirect coincident with imem_rsp_valid in WAIT -> response discarded, REQ immediately with redirect address.
REQ-038 pc=32'hFFFF_FFFC fetch completes -> next imem_addr 32'h0000_0000.
REQ-039 rst pulsed low while in WAIT with inst_valid=1 -> all outputs reset immediately, restart at RESET_PC.
